// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host receiver: synchronises and filters the pad signals, deserialises
// 11-bit frames, checks framing/odd parity and folds E0/F0 prefixes into key flags.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] key_in,
  output logic       is_extend,
  output logic       is_break,
  output logic       valid,
  output logic       err
);

  // state  | meaning
  // IDLE   | waiting for a start bit
  // DATA   | shifting in d0..d7
  // PARITY | capturing the parity bit
  // STOP   | checking the stop bit, frame ends on this fall
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state, state_n;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, fall;
  logic [FW-1:0] filt_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, byte_q;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          frame_end, frame_ok, tmo;
  logic          good_q, bad_q;
  logic          ext_flag, brk_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      clk_s1  <= PS2_CLK;
      clk_s2  <= clk_s1;
      data_s1 <= PS2_DATA;
      data_s2 <= data_s1;
      fall    <= 1'b0;
      // Level is accepted only after FILTER_LEN consecutive differing samples
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_cnt <= '0;
        filt_clk <= clk_s2;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    frame_end = 1'b0;
    frame_ok  = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE:   if (fall && !data_s2) state_n = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_n = PARITY;
      PARITY: if (fall) state_n = STOP;
      STOP: begin
        if (fall) begin
          state_n   = IDLE;
          frame_end = 1'b1;
          frame_ok  = data_s2 & (^{shreg, par_bit});
        end
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      tmo     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
      good_q  <= 1'b0;
      bad_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {data_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= data_s2;
          default: ;
        endcase
      end
      good_q <= frame_end & frame_ok;
      bad_q  <= (frame_end & ~frame_ok) | tmo;
      byte_q <= shreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_in    <= 8'h00;
      is_extend <= 1'b0;
      is_break  <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      err       <= 1'b0;
      is_extend <= 1'b0;
      is_break  <= 1'b0;
      if (good_q) begin
        if (byte_q == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          key_in    <= byte_q;
          valid     <= 1'b1;
          is_extend <= ext_flag;
          is_break  <= brk_flag;
          ext_flag  <= 1'b0;
          brk_flag  <= 1'b0;
        end
      end else if (bad_q) begin
        err      <= 1'b1;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Scoreboard bench for ps2_frame_receiver: directed PS/2 frames, expected events queued
// at stimulus time and checked by an independent output monitor.
module tb_ps2_frame_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 600;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] key_in;
  logic       is_extend, is_break, valid, err;

  typedef struct {
    bit         is_err;
    logic [7:0] key;
    bit         ext;
    bit         brk;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_fall = 0;

  ps2_frame_receiver #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .key_in(key_in), .is_extend(is_extend), .is_break(is_break),
    .valid(valid), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic push(input bit is_err, input logic [7:0] key, input bit ext, input bit brk);
    exp_t e;
    e.is_err = is_err; e.key = key; e.ext = ext; e.brk = brk;
    exp_q.push_back(e);
  endtask

  // One bit: data set up while clock is high, then a low half and a high half
  task automatic ps2_bit(input logic b, input bit glitch);
    @(negedge clk);
    PS2_DATA = b;
    repeat (HALF / 2) @(negedge clk);
    PS2_CLK = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    PS2_CLK = 1'b1;
    if (glitch) begin
      repeat (10) @(negedge clk);
      PS2_CLK = 1'b0;
      repeat (FILTER_LEN - 1) @(negedge clk);
      PS2_CLK = 1'b1;
      repeat (HALF - 10 - (FILTER_LEN - 1)) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input bit bad_par, input logic stop_b,
                           input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {stop_b, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i], i == glitch_bit);
    @(negedge clk);
    PS2_DATA = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(d, 1'b0, 1'b1, 11, -1);
  endtask

  task automatic chk_idle(input string name);
    chk(name, valid == 1'b0 && err == 1'b0 && key_in == 8'h00 && is_extend == 1'b0 && is_break == 1'b0,
        $sformatf("valid=%b err=%b key_in=%h ext=%b brk=%b, required all 0",
                  valid, err, key_in, is_extend, is_break));
  endtask

  always @(negedge clk) begin
    if (!rst && (valid || err)) begin
      exp_t e;
      chk("valid_err_exclusive", !(valid && err), $sformatf("valid=%b err=%b both high", valid, err));
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1'b0, $sformatf("valid=%b err=%b key_in=%h with nothing expected",
                                                valid, err, key_in));
      end else begin
        e = exp_q.pop_front();
        chk("event", err == e.is_err && valid == !e.is_err && key_in == e.key &&
                     is_extend == e.ext && is_break == e.brk,
            $sformatf("got err=%b valid=%b key=%h ext=%b brk=%b, required err=%b valid=%b key=%h ext=%b brk=%b",
                      err, valid, key_in, is_extend, is_break,
                      e.is_err, !e.is_err, e.key, e.ext, e.brk));
        if (valid)
          chk("latency", cyc - last_fall == FILTER_LEN + 4,
              $sformatf("got %0d cycles, required %0d", cyc - last_fall, FILTER_LEN + 4));
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    chk_idle("reset_state");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk_idle("after_reset_release");

    push(0, 8'h29, 0, 0); send(8'h29);

    push(0, 8'h75, 1, 1); send(8'hE0); send(8'hF0); send(8'h75);
    push(0, 8'h5A, 0, 0); send(8'h5A);

    push(1, 8'h5A, 0, 0); send_bits(8'h5A, 1'b1, 1'b1, 11, -1);
    send(8'hE0);
    push(1, 8'h5A, 0, 0); send_bits(8'h11, 1'b1, 1'b1, 11, -1);
    push(0, 8'h72, 0, 0); send(8'h72);

    push(1, 8'h72, 0, 0); send_bits(8'h1C, 1'b0, 1'b0, 11, -1);
    push(1, 8'h72, 0, 0); send_bits(8'h1C, 1'b0, 1'b1, 4, -1);
    repeat (TIMEOUT + 50) @(negedge clk);
    push(0, 8'h1C, 0, 0); send(8'h1C);

    push(0, 8'h34, 0, 0); send_bits(8'h34, 1'b0, 1'b1, 11, 4);

    push(0, 8'hE0 ^ 8'h4A, 0, 0); send(8'hE0 ^ 8'h4A);
    send(8'hE0); send(8'hE0);
    push(0, 8'h6C, 1, 0); send(8'h6C);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset_again");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    push(0, 8'hAA, 0, 0); send(8'hAA);

    send(8'hE0);
    send_bits(8'h6B, 1'b0, 1'b1, 6, -1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("reset_mid_frame");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    push(0, 8'h6B, 0, 0); send(8'h6B);

    repeat (200) @(negedge clk);
    chk("scoreboard_drained", exp_q.size() == 0,
        $sformatf("%0d expected events never seen, required 0", exp_q.size()));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
